// File: rtl/spi_temp_reader.sv
// Round-robin SPI mode-0 reader for LM07-class sensors: per-channel CS_N, shared SCK, MSB-first capture.
// Define SPI_TEMP_SIGN_MAG_EN to deliver the captured value as sign + saturated magnitude.
module spi_temp_reader #(
  parameter int N_CH       = 2,
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 8,
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 18,
  parameter int CHW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 SYSCLK,
  input  logic                 RSTN,
  input  logic                 EN,
  input  logic                 SIO,
  output logic [N_CH-1:0]      CS_N,
  output logic                 SCK,
  output logic [DATA_BITS-1:0] sample_data,
  output logic                 sample_neg,
  output logic [CHW-1:0]       sample_ch,
  output logic                 sample_valid,
  output logic                 busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]     DIV_ONE   = DIV_W'(1);
  localparam logic [BIT_W-1:0]     BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0]     DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]     BIT_ONE   = BIT_W'(1);
  localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0]     GAP_ONE   = GAP_W'(1);
  localparam logic [CHW-1:0]       PTR_LAST  = CHW'(N_CH - 1);
  localparam logic [CHW-1:0]       PTR_ONE   = CHW'(1);
  localparam logic [N_CH-1:0]      CS_ONE    = N_CH'(1);
  localparam logic [DATA_BITS-1:0] DATA_ONE  = DATA_BITS'(1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, GAP} state_t;

  state_t                 state_q, state_d;
  logic [N_CH-1:0]        cs_n_q, cs_n_d;
  logic                   sck_q, sck_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [CHW-1:0]         ptr_q, ptr_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   neg_q, neg_d;
  logic [CHW-1:0]         ch_q, ch_d;
  logic                   valid_q, valid_d;

  logic                   start_frame, take_bit, end_gap;
  logic [BIT_W-1:0]       next_bit;
  logic [DATA_BITS-1:0]   cap_data;
  logic                   cap_neg;

`ifdef SPI_TEMP_SIGN_MAG_EN
  localparam logic [DATA_BITS-1:0] MOST_NEG = DATA_ONE << (DATA_BITS - 1);
  localparam logic [DATA_BITS-1:0] MAX_POS  = MOST_NEG - DATA_ONE;

  always_comb begin
    cap_neg  = shreg_q[DATA_BITS-1];
    cap_data = shreg_q;
    if (shreg_q == MOST_NEG) cap_data = MAX_POS;
    else if (cap_neg)        cap_data = ~shreg_q + DATA_ONE;
  end
`else
  always_comb begin
    cap_neg  = 1'b0;
    cap_data = shreg_q;
  end
`endif

  // NOTE: every variable gets its hold value first so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cs_n_d      = cs_n_q;
    sck_d       = sck_q;
    div_d       = div_q;
    bit_d       = bit_q;
    gap_d       = gap_q;
    shreg_d     = shreg_q;
    ptr_d       = ptr_q;
    data_d      = data_q;
    neg_d       = neg_q;
    ch_d        = ch_q;
    valid_d     = 1'b0;
    start_frame = 1'b0;
    take_bit    = 1'b0;
    end_gap     = 1'b0;
    next_bit    = bit_q;

    case (state_q)
      IDLE: if (EN) start_frame = 1'b1;
      SETUP: begin
        if (div_q == DIV_LAST) begin
          div_d    = '0;
          sck_d    = 1'b1;
          take_bit = 1'b1;
          state_d  = SHIFT;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      SHIFT: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + DIV_ONE;
        end else begin
          div_d = '0;
          if (sck_q) begin
            sck_d = 1'b0;
          end else if (bit_q == BIT_LAST) begin
            state_d = DONE;
            cs_n_d  = '1;
            data_d  = cap_data;
            neg_d   = cap_neg;
            ch_d    = ptr_q;
            valid_d = 1'b1;
            ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_ONE;
            gap_d   = GAP_ONE;
          end else begin
            next_bit = bit_q + BIT_ONE;
            bit_d    = next_bit;
            sck_d    = 1'b1;
            take_bit = 1'b1;
          end
        end
      end
      // The DONE cycle is the first of the inter-frame gap.
      DONE: begin
        if (GAP_LAST == '0) end_gap = 1'b1;
        else                state_d = GAP;
      end
      GAP: begin
        if (gap_q == GAP_LAST) end_gap = 1'b1;
        else                   gap_d = gap_q + GAP_ONE;
      end
      default: state_d = IDLE;
    endcase

    if (end_gap) begin
      if (EN) start_frame = 1'b1;
      else    state_d = IDLE;
    end

    if (start_frame) begin
      state_d = SETUP;
      cs_n_d  = ~(CS_ONE << ptr_q);
      shreg_d = '0;
      bit_d   = '0;
      div_d   = '0;
    end

    // Bits past the data field are still clocked but never enter the shift register.
    if (take_bit && (next_bit <= DATA_LAST)) shreg_d = (shreg_q << 1) | DATA_BITS'(SIO);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cs_n_q  <= '1;
      sck_q   <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      shreg_q <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      neg_q   <= 1'b0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      shreg_q <= shreg_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      neg_q   <= neg_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
    end
  end

  assign CS_N         = cs_n_q;
  assign SCK          = sck_q;
  assign sample_data  = data_q;
  assign sample_neg   = neg_q;
  assign sample_ch    = ch_q;
  assign sample_valid = valid_q;
  assign busy         = ~&cs_n_q;

endmodule

// File: tb/tb_spi_temp_reader.sv
// Directed bench for spi_temp_reader: a default 2-channel instance plus a 1-channel, CLK_DIV=1, 8-bit-frame instance.
module tb_spi_temp_reader;

  localparam int GAP2 = 3;
`ifdef SPI_TEMP_SIGN_MAG_EN
  localparam bit SM = 1'b1;
`else
  localparam bit SM = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       neg;
    logic       ch;
  } strobe_t;

  logic       SYSCLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       EN = 1'b0;
  logic       EN2 = 1'b0;
  logic       SIO = 1'b0;
  logic       SIO2 = 1'b0;
  logic [1:0] CS_N;
  logic       SCK;
  logic [7:0] sample_data;
  logic       sample_neg;
  logic [0:0] sample_ch;
  logic       sample_valid;
  logic       busy;
  logic [0:0] CS_N2;
  logic       SCK2;
  logic [7:0] sample_data2;
  logic       sample_neg2;
  logic [0:0] sample_ch2;
  logic       sample_valid2;
  logic       busy2;

  int compared = 0;
  int mismatched = 0;

  logic [15:0] words [2];
  logic [7:0]  words2 [2];

  always #5 SYSCLK = ~SYSCLK;

  spi_temp_reader #(.N_CH(2), .FRAME_BITS(16), .DATA_BITS(8), .CLK_DIV(2), .GAP_CYCLES(18)) dut (
    .SYSCLK(SYSCLK), .RSTN(RSTN), .EN(EN), .SIO(SIO), .CS_N(CS_N), .SCK(SCK),
    .sample_data(sample_data), .sample_neg(sample_neg), .sample_ch(sample_ch),
    .sample_valid(sample_valid), .busy(busy));

  spi_temp_reader #(.N_CH(1), .FRAME_BITS(8), .DATA_BITS(8), .CLK_DIV(1), .GAP_CYCLES(GAP2)) dut2 (
    .SYSCLK(SYSCLK), .RSTN(RSTN), .EN(EN2), .SIO(SIO2), .CS_N(CS_N2), .SCK(SCK2),
    .sample_data(sample_data2), .sample_neg(sample_neg2), .sample_ch(sample_ch2),
    .sample_valid(sample_valid2), .busy(busy2));

  // Sensor models: present the frame MSB first, advance on each SCK falling edge.
  int   idx1 = 0;
  logic m1_sck_prev = 1'b0;
  always @(negedge SYSCLK) begin
    if (&CS_N) idx1 = 0;
    else if (m1_sck_prev && !SCK) idx1 = idx1 + 1;
    m1_sck_prev = SCK;
    if (!(&CS_N) && idx1 < 16) SIO = words[CS_N[0] ? 1 : 0][15 - idx1];
    else SIO = 1'b0;
  end

  int   idx2 = 0;
  int   fr2 = 0;
  logic m2_sck_prev = 1'b0;
  logic m2_cs_prev = 1'b1;
  always @(negedge SYSCLK) begin
    if (CS_N2[0] === 1'b1) begin
      idx2 = 0;
      if (m2_cs_prev === 1'b0) fr2 = fr2 + 1;
    end else if (m2_sck_prev && !SCK2) idx2 = idx2 + 1;
    m2_sck_prev = SCK2;
    m2_cs_prev  = CS_N2[0];
    if (CS_N2[0] === 1'b0 && idx2 < 8) SIO2 = words2[fr2 % 2][7 - idx2];
    else SIO2 = 1'b0;
  end

  // Monitors: log frame lengths, SCK pulses, gaps and strobes; count protocol violations.
  int      low_run = 0, high_run = 0, rises = 0;
  logic    prev_cs_low = 1'b0, prev_sck = 1'b0, prev_valid = 1'b0;
  int      overlap_err = 0, sck_idle_err = 0, dbl_err = 0, busy_err = 0;
  int      len_q[$], rise_q[$], gap_q[$], start_ch_q[$];
  strobe_t strobe_q[$];

  always @(negedge SYSCLK) begin
    logic cs_low;
    cs_low = ~&CS_N;
    if (cs_low) begin
      if (!prev_cs_low) begin
        gap_q.push_back(high_run);
        start_ch_q.push_back(CS_N[0] ? 1 : 0);
      end
      low_run  = low_run + 1;
      high_run = 0;
      if (SCK && !prev_sck) rises = rises + 1;
    end else begin
      if (prev_cs_low) begin
        len_q.push_back(low_run);
        rise_q.push_back(rises);
      end
      low_run  = 0;
      rises    = 0;
      high_run = high_run + 1;
      if (SCK !== 1'b0) sck_idle_err = sck_idle_err + 1;
    end
    if ($countones(~CS_N) > 1) overlap_err = overlap_err + 1;
    if (busy !== cs_low) busy_err = busy_err + 1;
    if (sample_valid === 1'b1) begin
      if (prev_valid) dbl_err = dbl_err + 1;
      strobe_q.push_back({sample_data, sample_neg, sample_ch[0]});
    end
    prev_cs_low = cs_low;
    prev_sck    = SCK;
    prev_valid  = (sample_valid === 1'b1);
  end

  int      low_run2 = 0, high_run2 = 0, rises2 = 0;
  logic    prev_cs2_low = 1'b0, prev_sck2 = 1'b0;
  int      len2_q[$], rise2_q[$], gap2_q[$];
  strobe_t strobe2_q[$];

  always @(negedge SYSCLK) begin
    if (CS_N2[0] === 1'b0) begin
      if (!prev_cs2_low) gap2_q.push_back(high_run2);
      low_run2  = low_run2 + 1;
      high_run2 = 0;
      if (SCK2 && !prev_sck2) rises2 = rises2 + 1;
    end else begin
      if (prev_cs2_low) begin
        len2_q.push_back(low_run2);
        rise2_q.push_back(rises2);
      end
      low_run2  = 0;
      rises2    = 0;
      high_run2 = high_run2 + 1;
    end
    if (sample_valid2 === 1'b1) strobe2_q.push_back({sample_data2, sample_neg2, sample_ch2[0]});
    prev_cs2_low = (CS_N2[0] === 1'b0);
    prev_sck2    = SCK2;
  end

  int sb, lb, gb, cb, s2b, l2b, g2b;

  task automatic mark();
    sb  = strobe_q.size();
    lb  = len_q.size();
    gb  = gap_q.size();
    cb  = start_ch_q.size();
    s2b = strobe2_q.size();
    l2b = len2_q.size();
    g2b = gap2_q.size();
  endtask

  task automatic do_reset();
    @(posedge SYSCLK); #2;
    RSTN = 1'b0; EN = 1'b0; EN2 = 1'b0;
    repeat (3) @(posedge SYSCLK);
    #2 RSTN = 1'b1;
    @(posedge SYSCLK); #2;
  endtask

  task automatic wait_strobes(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && strobe_q.size() < n; i++) begin
      @(posedge SYSCLK); #2;
    end
    compared++;
    if (strobe_q.size() < n) begin
      mismatched++;
      $display("FAIL %s_timeout: strobes %0d, required %0d", tag, strobe_q.size(), n);
    end
  endtask

  task automatic wait_rises(input int frames, input int k, input int budget, input string tag);
    for (int i = 0; i < budget && !(start_ch_q.size() >= frames && rises >= k); i++) begin
      @(posedge SYSCLK); #2;
    end
    compared++;
    if (!(start_ch_q.size() >= frames && rises >= k)) begin
      mismatched++;
      $display("FAIL %s_timeout: frames %0d rises %0d, required %0d/%0d", tag, start_ch_q.size(), rises, frames, k);
    end
  endtask

  task automatic test_reset();
    @(posedge SYSCLK); #2;
    compared++;
    if (CS_N !== 2'b11) begin mismatched++; $display("FAIL reset_cs_n: got %b want 11", CS_N); end
    compared++;
    if (SCK !== 1'b0) begin mismatched++; $display("FAIL reset_sck: got %b want 0", SCK); end
    compared++;
    if ({sample_data, sample_neg, sample_ch} !== 10'h000) begin
      mismatched++;
      $display("FAIL reset_sample: data %h neg %b ch %b, want 00/0/0", sample_data, sample_neg, sample_ch);
    end
    compared++;
    if ({sample_valid, busy} !== 2'b00) begin
      mismatched++; $display("FAIL reset_valid_busy: got %b%b want 00", sample_valid, busy);
    end
    compared++;
    if ({CS_N2, SCK2, busy2, sample_valid2} !== 4'b1000) begin
      mismatched++; $display("FAIL reset_dut2: got %b%b%b%b want 1000", CS_N2, SCK2, busy2, sample_valid2);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    words[0] = 16'h19A5; words[1] = 16'h2A3C;
    mark();
    EN = 1'b1;
    wait_strobes(sb + 1, 300, "single");
    EN = 1'b0;
    repeat (40) @(posedge SYSCLK);
    #2;
    compared++;
    if (strobe_q.size() !== sb + 1) begin
      mismatched++; $display("FAIL single_strobe_count: got %0d want %0d", strobe_q.size() - sb, 1);
    end
    compared++;
    if (strobe_q[sb] !== {8'h19, 1'b0, 1'b0}) begin
      mismatched++; $display("FAIL single_sample: got %h want %h", strobe_q[sb], {8'h19, 1'b0, 1'b0});
    end
    compared++;
    if (len_q[lb] !== 66) begin mismatched++; $display("FAIL single_cs_low_len: got %0d want 66", len_q[lb]); end
    compared++;
    if (rise_q[lb] !== 16) begin mismatched++; $display("FAIL single_sck_pulses: got %0d want 16", rise_q[lb]); end
    compared++;
    if (start_ch_q[cb] !== 0) begin mismatched++; $display("FAIL single_start_ch: got %0d want 0", start_ch_q[cb]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mark();
    EN = 1'b1;
    wait_strobes(sb + 4, 600, "b2b");
    EN = 1'b0;
    repeat (40) @(posedge SYSCLK);
    #2;
    compared++;
    if (strobe_q.size() !== sb + 4) begin
      mismatched++; $display("FAIL b2b_strobe_count: got %0d want 4", strobe_q.size() - sb);
    end
    for (int i = 0; i < 4; i++) begin
      strobe_t exp;
      exp = (i % 2 == 0) ? {8'h19, 1'b0, 1'b0} : {8'h2A, 1'b0, 1'b1};
      compared++;
      if (strobe_q[sb + i] !== exp) begin
        mismatched++; $display("FAIL b2b_sample_%0d: got %h want %h", i, strobe_q[sb + i], exp);
      end
      compared++;
      if (len_q[lb + i] !== 66) begin
        mismatched++; $display("FAIL b2b_cs_low_len_%0d: got %0d want 66", i, len_q[lb + i]);
      end
    end
    for (int i = 1; i < 4; i++) begin
      compared++;
      if (gap_q[gb + i] !== 18) begin
        mismatched++; $display("FAIL b2b_gap_%0d: got %0d want 18", i, gap_q[gb + i]);
      end
    end
    compared++;
    if ({overlap_err, sck_idle_err, dbl_err, busy_err} !== 128'd0) begin
      mismatched++;
      $display("FAIL b2b_protocol: overlap %0d sck_idle %0d double_valid %0d busy %0d, want all 0",
               overlap_err, sck_idle_err, dbl_err, busy_err);
    end
  endtask

  task automatic test_en_drop();
    do_reset();
    mark();
    EN = 1'b1;
    wait_rises(cb + 1, 5, 200, "endrop_edge");
    EN = 1'b0;
    wait_strobes(sb + 1, 200, "endrop");
    compared++;
    if (strobe_q[sb] !== {8'h19, 1'b0, 1'b0}) begin
      mismatched++; $display("FAIL endrop_sample: got %h want %h", strobe_q[sb], {8'h19, 1'b0, 1'b0});
    end
    repeat (30) @(posedge SYSCLK);
    #2;
    compared++;
    if ({CS_N, SCK, busy} !== 4'b1100) begin
      mismatched++; $display("FAIL endrop_idle_pins: got %b%b%b want 1100", CS_N, SCK, busy);
    end
    repeat (100) @(posedge SYSCLK);
    #2;
    compared++;
    if (strobe_q.size() !== sb + 1 || start_ch_q.size() !== cb + 1) begin
      mismatched++;
      $display("FAIL endrop_no_more_frames: strobes %0d frames %0d, want 1/1", strobe_q.size() - sb, start_ch_q.size() - cb);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    mark();
    EN = 1'b1;
    wait_rises(cb + 2, 10, 400, "rstmid_edge");
    RSTN = 1'b0;
    #1;
    compared++;
    if ({CS_N, SCK, busy} !== 4'b1100) begin
      mismatched++; $display("FAIL rstmid_async: got %b%b%b want 1100", CS_N, SCK, busy);
    end
    repeat (3) @(posedge SYSCLK);
    #2;
    compared++;
    if (strobe_q.size() !== sb + 1) begin
      mismatched++; $display("FAIL rstmid_no_strobe: got %0d strobes want 1", strobe_q.size() - sb);
    end
    RSTN = 1'b1;
    wait_strobes(sb + 2, 300, "rstmid");
    EN = 1'b0;
    compared++;
    if (start_ch_q[cb + 2] !== 0) begin
      mismatched++; $display("FAIL rstmid_restart_ch: got %0d want 0", start_ch_q[cb + 2]);
    end
    compared++;
    if (strobe_q[sb + 1] !== {8'h19, 1'b0, 1'b0}) begin
      mismatched++; $display("FAIL rstmid_sample: got %h want %h", strobe_q[sb + 1], {8'h19, 1'b0, 1'b0});
    end
    compared++;
    if (len_q[lb + 2] !== 66) begin mismatched++; $display("FAIL rstmid_cs_low_len: got %0d want 66", len_q[lb + 2]); end
    repeat (30) @(posedge SYSCLK);
  endtask

  task automatic test_sign_mag();
    strobe_t exp0, exp1;
    exp0 = SM ? {8'h19, 1'b1, 1'b0} : {8'hE7, 1'b0, 1'b0};
    exp1 = SM ? {8'h7F, 1'b1, 1'b1} : {8'h80, 1'b0, 1'b1};
    do_reset();
    words[0] = 16'hE712; words[1] = 16'h80FF;
    mark();
    EN = 1'b1;
    wait_strobes(sb + 2, 400, "signmag");
    EN = 1'b0;
    compared++;
    if (strobe_q[sb] !== exp0) begin mismatched++; $display("FAIL signmag_e7: got %h want %h", strobe_q[sb], exp0); end
    compared++;
    if (strobe_q[sb + 1] !== exp1) begin mismatched++; $display("FAIL signmag_80: got %h want %h", strobe_q[sb + 1], exp1); end
    repeat (30) @(posedge SYSCLK);
    words[0] = 16'h19A5; words[1] = 16'h2A3C;
  endtask

  task automatic test_small_config();
    strobe_t exp0, exp1;
    exp0 = {8'h5C, 1'b0, 1'b0};
    exp1 = SM ? {8'h3D, 1'b1, 1'b0} : {8'hC3, 1'b0, 1'b0};
    do_reset();
    mark();
    EN2 = 1'b1;
    for (int i = 0; i < 200 && strobe2_q.size() < s2b + 2; i++) begin
      @(posedge SYSCLK); #2;
    end
    EN2 = 1'b0;
    compared++;
    if (strobe2_q.size() < s2b + 2) begin
      mismatched++; $display("FAIL small_timeout: strobes %0d want 2", strobe2_q.size() - s2b);
    end
    repeat (20) @(posedge SYSCLK);
    #2;
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (len2_q[l2b + i] !== 17) begin
        mismatched++; $display("FAIL small_cs_low_len_%0d: got %0d want 17", i, len2_q[l2b + i]);
      end
      compared++;
      if (rise2_q[l2b + i] !== 8) begin
        mismatched++; $display("FAIL small_sck_pulses_%0d: got %0d want 8", i, rise2_q[l2b + i]);
      end
    end
    compared++;
    if (strobe2_q[s2b] !== exp0) begin mismatched++; $display("FAIL small_sample_0: got %h want %h", strobe2_q[s2b], exp0); end
    compared++;
    if (strobe2_q[s2b + 1] !== exp1) begin mismatched++; $display("FAIL small_sample_1: got %h want %h", strobe2_q[s2b + 1], exp1); end
    compared++;
    if (gap2_q[g2b + 1] !== GAP2) begin mismatched++; $display("FAIL small_gap: got %0d want %0d", gap2_q[g2b + 1], GAP2); end
    compared++;
    if (strobe2_q.size() !== s2b + 2) begin
      mismatched++; $display("FAIL small_strobe_count: got %0d want 2", strobe2_q.size() - s2b);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    words[0] = 16'h19A5; words[1] = 16'h2A3C;
    words2[0] = 8'h5C;   words2[1] = 8'hC3;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_en_drop();
    test_reset_mid_frame();
    test_sign_mag();
    test_small_config();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
